// File: rtl/cache_axi_bridge_pkg.sv
// Shared constants, type encodings and FSM state types for the cache-to-AXI bridge.
// Request types follow the cache encoding: 0 byte, 1 half, 2 word, 4 line.
package cache_axi_bridge_pkg;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [2:0] AxiSize4B    = 3'd2;
  localparam logic [7:0] AxiLenLine   = 8'd3;
  localparam logic [7:0] AxiLenSingle = 8'd0;
  localparam logic [3:0] WstrbFull    = 4'hF;

  localparam logic [2:0] TypeByte = 3'd0;
  localparam logic [2:0] TypeHalf = 3'd1;
  localparam logic [2:0] TypeWord = 3'd2;
  localparam logic [2:0] TypeLine = 3'd4;

  localparam logic [3:0] DefIcId = 4'd0;
  localparam logic [3:0] DefDcId = 4'd1;

  typedef enum logic [1:0] {RIdle, RAr, RData} rd_state_e;
  typedef enum logic [1:0] {WIdle, WAw, WData, WB} wr_state_e;

  function automatic logic [7:0] axi_len(input logic [2:0] typ);
    return (typ == TypeLine) ? AxiLenLine : AxiLenSingle;
  endfunction

  // A line moves as 4-byte beats; single transfers use the request width directly.
  function automatic logic [2:0] axi_size(input logic [2:0] typ);
    return (typ == TypeLine) ? AxiSize4B : {1'b0, typ[1:0]};
  endfunction

endpackage

// File: rtl/cache_axi_bridge_wr_serializer.sv
// Splits a captured 128-bit write line into W beats, lowest word first.
// The beat counter advances only on an accepted beat, so wdata is stable under back-pressure.
module axi_wr_serializer
  import cache_axi_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_valid,
  input  logic         i_line,
  input  logic [3:0]   i_wstrb,
  input  logic [127:0] i_data,
  input  logic         i_wready,
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_wstrb,
  output logic         o_wlast,
  output logic         o_done
);

  logic [1:0] r_cnt;
  logic       w_last;
  logic       w_fire;

  assign w_last = i_line ? (r_cnt == 2'd3) : (r_cnt == 2'd0);
  assign w_fire = i_valid && i_wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= 2'd0;
    end else if (w_fire) begin
      r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
    end
  end

  assign o_wdata = i_data[{r_cnt, 5'd0} +: 32];
  assign o_wstrb = i_line ? WstrbFull : i_wstrb;
  assign o_wlast = w_last;
  assign o_done  = w_fire && w_last;

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridges icache/dcache read requests and dcache write requests onto one AXI master port.
// Read and write FSMs run independently; reads to a line held in the write buffer wait.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter logic [3:0] IC_ID = DefIcId,
  parameter logic [3:0] DC_ID = DefDcId
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_ic_rd_req,
  input  logic [2:0]   i_ic_rd_type,
  input  logic [31:0]  i_ic_rd_addr,
  output logic         o_ic_rd_rdy,
  output logic         o_ic_ret_valid,
  output logic         o_ic_ret_last,
  output logic [31:0]  o_ic_ret_data,
  input  logic         i_dc_rd_req,
  input  logic [2:0]   i_dc_rd_type,
  input  logic [31:0]  i_dc_rd_addr,
  output logic         o_dc_rd_rdy,
  output logic         o_dc_ret_valid,
  output logic         o_dc_ret_last,
  output logic [31:0]  o_dc_ret_data,
  input  logic         i_dc_wr_req,
  input  logic [2:0]   i_dc_wr_type,
  input  logic [31:0]  i_dc_wr_addr,
  input  logic [3:0]   i_dc_wr_wstrb,
  input  logic [127:0] i_dc_wr_data,
  output logic         o_dc_wr_rdy,
  output logic         o_dc_data_write_ok,
  output logic [3:0]   o_arid,
  output logic [31:0]  o_araddr,
  output logic [7:0]   o_arlen,
  output logic [2:0]   o_arsize,
  output logic [1:0]   o_arburst,
  output logic         o_arvalid,
  input  logic         i_arready,
  input  logic [3:0]   i_rid,
  input  logic [31:0]  i_rdata,
  input  logic [1:0]   i_rresp,
  input  logic         i_rlast,
  input  logic         i_rvalid,
  output logic         o_rready,
  output logic [3:0]   o_awid,
  output logic [31:0]  o_awaddr,
  output logic [7:0]   o_awlen,
  output logic [2:0]   o_awsize,
  output logic [1:0]   o_awburst,
  output logic         o_awvalid,
  input  logic         i_awready,
  output logic [3:0]   o_wid,
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_wstrb,
  output logic         o_wlast,
  output logic         o_wvalid,
  input  logic         i_wready,
  input  logic [3:0]   i_bid,
  input  logic [1:0]   i_bresp,
  input  logic         i_bvalid,
  output logic         o_bready
);

  rd_state_e    r_rd_state;
  wr_state_e    r_wr_state;
  logic [31:0]  r_rd_addr;
  logic [2:0]   r_rd_type;
  logic [3:0]   r_rd_id;
  logic         r_arvalid;
  logic         r_rready;
  logic [31:0]  r_wr_addr;
  logic [2:0]   r_wr_type;
  logic [3:0]   r_wr_wstrb;
  logic [127:0] r_wr_data;
  logic         r_awvalid;
  logic         r_wvalid;
  logic         r_bready;
  logic         r_wr_rdy;
  logic         r_write_ok;

  logic w_rd_idle, w_wr_busy, w_dc_hazard, w_ic_hazard, w_dc_grant, w_ic_grant;
  logic w_rbeat, w_wdone, w_unused_ok;

  // Response codes and bid carry nothing this bridge acts on.
  assign w_unused_ok = ^{i_rresp, i_bresp, i_bid};

  assign w_rd_idle   = resetn && (r_rd_state == RIdle);
  assign w_wr_busy   = (r_wr_state != WIdle);
  assign w_dc_hazard = w_wr_busy && (i_dc_rd_addr[31:4] == r_wr_addr[31:4]);
  assign w_ic_hazard = w_wr_busy && (i_ic_rd_addr[31:4] == r_wr_addr[31:4]);
  assign w_dc_grant  = w_rd_idle && i_dc_rd_req && !w_dc_hazard;
  assign w_ic_grant  = w_rd_idle && i_ic_rd_req && !w_ic_hazard && !w_dc_grant;

  assign o_dc_rd_rdy = w_dc_grant;
  assign o_ic_rd_rdy = w_ic_grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_state <= RIdle;
      r_rd_addr  <= '0;
      r_rd_type  <= '0;
      r_rd_id    <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      unique case (r_rd_state)
        RIdle: begin
          if (w_dc_grant || w_ic_grant) begin
            r_rd_addr  <= w_dc_grant ? i_dc_rd_addr : i_ic_rd_addr;
            r_rd_type  <= w_dc_grant ? i_dc_rd_type : i_ic_rd_type;
            r_rd_id    <= w_dc_grant ? DC_ID : IC_ID;
            r_arvalid  <= 1'b1;
            r_rd_state <= RAr;
          end
        end
        RAr: begin
          if (i_arready) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_rd_state <= RData;
          end
        end
        RData: begin
          if (i_rvalid && i_rlast) begin
            r_rready   <= 1'b0;
            r_rd_state <= RIdle;
          end
        end
        default: r_rd_state <= RIdle;
      endcase
    end
  end

  assign o_arid    = r_rd_id;
  assign o_araddr  = r_rd_addr;
  assign o_arlen   = axi_len(r_rd_type);
  assign o_arsize  = axi_size(r_rd_type);
  assign o_arburst = AxiBurstIncr;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

  assign w_rbeat        = r_rready && i_rvalid;
  assign o_ic_ret_valid = w_rbeat && (i_rid == IC_ID);
  assign o_dc_ret_valid = w_rbeat && (i_rid == DC_ID);
  assign o_ic_ret_last  = i_rlast;
  assign o_dc_ret_last  = i_rlast;
  assign o_ic_ret_data  = i_rdata;
  assign o_dc_ret_data  = i_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_state <= WIdle;
      r_wr_addr  <= '0;
      r_wr_type  <= '0;
      r_wr_wstrb <= '0;
      r_wr_data  <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_wr_rdy   <= 1'b1;
      r_write_ok <= 1'b0;
    end else begin
      r_write_ok <= 1'b0;
      unique case (r_wr_state)
        WIdle: begin
          if (i_dc_wr_req) begin
            r_wr_addr  <= i_dc_wr_addr;
            r_wr_type  <= i_dc_wr_type;
            r_wr_wstrb <= i_dc_wr_wstrb;
            r_wr_data  <= i_dc_wr_data;
            r_awvalid  <= 1'b1;
            r_wr_rdy   <= 1'b0;
            r_wr_state <= WAw;
          end
        end
        WAw: begin
          if (i_awready) begin
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b1;
            r_wr_state <= WData;
          end
        end
        WData: begin
          if (w_wdone) begin
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b1;
            r_wr_state <= WB;
          end
        end
        WB: begin
          if (i_bvalid) begin
            r_bready   <= 1'b0;
            r_write_ok <= 1'b1;
            r_wr_rdy   <= 1'b1;
            r_wr_state <= WIdle;
          end
        end
        default: r_wr_state <= WIdle;
      endcase
    end
  end

  axi_wr_serializer u_wr_ser (
    .clk      (clk),
    .resetn   (resetn),
    .i_valid  (r_wvalid),
    .i_line   (r_wr_type == TypeLine),
    .i_wstrb  (r_wr_wstrb),
    .i_data   (r_wr_data),
    .i_wready (i_wready),
    .o_wdata  (o_wdata),
    .o_wstrb  (o_wstrb),
    .o_wlast  (o_wlast),
    .o_done   (w_wdone)
  );

  assign o_awid             = DC_ID;
  assign o_awaddr           = r_wr_addr;
  assign o_awlen            = axi_len(r_wr_type);
  assign o_awsize           = axi_size(r_wr_type);
  assign o_awburst          = AxiBurstIncr;
  assign o_awvalid          = r_awvalid;
  assign o_wid              = DC_ID;
  assign o_wvalid           = r_wvalid;
  assign o_bready           = r_bready;
  assign o_dc_wr_rdy        = r_wr_rdy;
  assign o_dc_data_write_ok = r_write_ok;

endmodule
